// File: rtl/capture_csr_bank_if.sv
// Avalon-MM slave bus bundle for capture_csr_bank: word address, single-cycle
// read/write strobes, byte lanes and registered read data with readdatavalid.
interface capture_csr_bank_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [N/8-1:0]    byteenable;
  logic [N-1:0]      writedata;
  logic [N-1:0]      readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/capture_csr_bank.sv
// Multi-channel CSR bank for the packet-capture datapath: config, live status,
// sticky W1C event flags, masked level irq. CSR_TIMESTAMP_EN adds cycle/done timestamps.
module capture_csr_bank #(
  parameter int          N       = 32,
  parameter int          NUM_CH  = 2,
  parameter int          ADDR_W  = 4,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                clk,
  input  logic                reset,
  capture_csr_bank_if.slave   bus,
  output logic                irq,
  input  logic [NUM_CH-1:0]   ch_busy,
  input  logic [NUM_CH-1:0]   ch_done,
  input  logic [NUM_CH-1:0]   ch_wrap,
  input  logic [NUM_CH*N-1:0] ch_last_write_addr,
  output logic                out_enable,
  output logic [NUM_CH*N-1:0] out_buf_start,
  output logic [NUM_CH*N-1:0] out_buf_size
);
  localparam int NF = 2 * NUM_CH;

  logic          r_enable;
  logic [NF-1:0] r_status;
  logic [NF-1:0] r_mask;
  logic          r_irq;
  logic [N-1:0]  r_readdata;
  logic          r_rdvalid;
  logic [N-1:0]  r_buf_start [NUM_CH];
  logic [N-1:0]  r_buf_size  [NUM_CH];
  logic [N-1:0]  r_pkt_cnt   [NUM_CH];
`ifdef CSR_TIMESTAMP_EN
  logic [N-1:0]  r_cycle;
  logic [N-1:0]  r_done_ts   [NUM_CH];
`endif

  logic [31:0]   w_addr;
  logic [N-1:0]  w_be_mask;
  logic          w_wr_ctrl;
  logic          w_soft_clr;
  logic [NF-1:0] w_set;
  logic [NF-1:0] w_clr;
  logic [N-1:0]  w_rd_data;

  assign w_addr     = 32'(bus.address);
  assign w_wr_ctrl  = bus.write && (w_addr == 32'd0);
  assign w_soft_clr = w_wr_ctrl && bus.writedata[1];

  always_comb begin
    w_be_mask = '0;
    for (int b = 0; b < N/8; b++) w_be_mask[b*8 +: 8] = {8{bus.byteenable[b]}};
  end

  always_comb begin
    w_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_set[2*c]   = ch_done[c];
      w_set[2*c+1] = ch_wrap[c];
    end
  end

  // Set is OR-ed in after the clear, so a coincident event wins over W1C.
  assign w_clr = w_soft_clr ? '1 :
                 (bus.write && (w_addr == 32'd1)) ? bus.writedata[NF-1:0] : '0;

  always_comb begin
    w_rd_data = '0;
    if (w_addr == 32'd0) begin
      w_rd_data[0]             = r_enable;
      w_rd_data[N-1 -: NUM_CH] = ch_busy;
    end else if (w_addr == 32'd1) begin
      w_rd_data[NF-1:0] = r_status;
    end else if (w_addr == 32'd2) begin
      w_rd_data[NF-1:0] = r_mask;
    end else if (w_addr == 32'd3) begin
`ifdef CSR_TIMESTAMP_EN
      w_rd_data = r_cycle;
`else
      w_rd_data = N'(VERSION);
`endif
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_addr == 32'(4 + 4*c))     w_rd_data = r_buf_start[c];
      if (w_addr == 32'(4 + 4*c + 1)) w_rd_data = r_buf_size[c];
      if (w_addr == 32'(4 + 4*c + 2)) w_rd_data = ch_last_write_addr[c*N +: N];
      if (w_addr == 32'(4 + 4*c + 3)) w_rd_data = r_pkt_cnt[c];
`ifdef CSR_TIMESTAMP_EN
      if (w_addr == 32'(4 + 4*NUM_CH + c)) w_rd_data = r_done_ts[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable   <= 1'b0;
      r_status   <= '0;
      r_mask     <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
      r_rdvalid  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_buf_start[c] <= '0;
        r_buf_size[c]  <= '0;
        r_pkt_cnt[c]   <= '0;
      end
`ifdef CSR_TIMESTAMP_EN
      r_cycle <= '0;
      for (int c = 0; c < NUM_CH; c++) r_done_ts[c] <= '0;
`endif
    end else begin
      if (w_wr_ctrl && bus.byteenable[0]) r_enable <= bus.writedata[0];
      r_status <= (r_status & ~w_clr) | w_set;
      if (bus.write && (w_addr == 32'd2))
        r_mask <= (r_mask & ~w_be_mask[NF-1:0]) | (bus.writedata[NF-1:0] & w_be_mask[NF-1:0]);
      r_irq     <= |(r_status & r_mask);
      r_rdvalid <= bus.read;
      if (bus.read) r_readdata <= w_rd_data;
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.write && (w_addr == 32'(4 + 4*c)))
          r_buf_start[c] <= (r_buf_start[c] & ~w_be_mask) | (bus.writedata & w_be_mask);
        if (bus.write && (w_addr == 32'(4 + 4*c + 1)))
          r_buf_size[c] <= (r_buf_size[c] & ~w_be_mask) | (bus.writedata & w_be_mask);
        // A clear coinciding with a done pulse still counts that packet.
        if (w_soft_clr || (bus.write && (w_addr == 32'(4 + 4*c + 3))))
          r_pkt_cnt[c] <= ch_done[c] ? N'(1) : '0;
        else if (ch_done[c] && (r_pkt_cnt[c] != '1))
          r_pkt_cnt[c] <= r_pkt_cnt[c] + N'(1);
      end
`ifdef CSR_TIMESTAMP_EN
      r_cycle <= r_cycle + N'(1);
      for (int c = 0; c < NUM_CH; c++)
        if (ch_done[c]) r_done_ts[c] <= r_cycle;
`endif
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_rdvalid;
  assign irq               = r_irq;
  assign out_enable        = r_enable;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_buf_start[c*N +: N] = r_buf_start[c];
    assign out_buf_size[c*N +: N]  = r_buf_size[c];
  end
endmodule

// File: tb/tb_capture_csr_bank.sv
// Directed bench for capture_csr_bank: register-map vector table followed by
// hand-written event, W1C, SOFT_CLR and read/write-collision sequences.
module tb_capture_csr_bank;
  localparam int N = 32, NUM_CH = 2, ADDR_W = 4;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              irq;
  logic [NUM_CH-1:0] ch_busy, ch_done, ch_wrap;
  logic [NUM_CH*N-1:0] ch_last_write_addr;
  logic              out_enable;
  logic [NUM_CH*N-1:0] out_buf_start, out_buf_size;

  int checks = 0;
  int errors = 0;

  capture_csr_bank_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  capture_csr_bank #(.N(N), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .VERSION(VER)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .irq                (irq),
    .ch_busy            (ch_busy),
    .ch_done            (ch_done),
    .ch_wrap            (ch_wrap),
    .ch_last_write_addr (ch_last_write_addr),
    .out_enable         (out_enable),
    .out_buf_start      (out_buf_start),
    .out_buf_size       (out_buf_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = d;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.write      = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    chk({nm, "_valid"}, 64'(bus.readdatavalid), 64'd1);
    chk(nm, 64'(bus.readdata), 64'(exp));
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] w);
    ch_done = d;
    ch_wrap = w;
    @(negedge clk);
    ch_done = '0;
    ch_wrap = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  4'h0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 4'd1,  4'h0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 4'd2,  4'h0, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 4'd3,  4'h0, 32'h0,         VER};
    vecs[4]  = '{1'b0, 4'd4,  4'h0, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 4'd5,  4'h0, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 4'd6,  4'h0, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 4'd7,  4'h0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 4'd8,  4'h0, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 4'd9,  4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 4'd10, 4'h0, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 4'd11, 4'h0, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 4'd8,  4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b1, 4'd8,  4'h3, 32'h2000_0000, 32'h0};
    vecs[14] = '{1'b0, 4'd8,  4'h0, 32'h0,         32'hFFFF_0000};
    vecs[15] = '{1'b1, 4'd4,  4'h1, 32'h1234_5678, 32'h0};
    vecs[16] = '{1'b0, 4'd4,  4'h0, 32'h0,         32'h0000_0078};
    vecs[17] = '{1'b1, 4'd5,  4'hC, 32'hAABB_CCDD, 32'h0};
    vecs[18] = '{1'b0, 4'd5,  4'h0, 32'h0,         32'hAABB_0000};
    vecs[19] = '{1'b1, 4'd2,  4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[20] = '{1'b0, 4'd2,  4'h0, 32'h0,         32'h0000_000F};
    vecs[21] = '{1'b1, 4'd2,  4'h1, 32'h0000_0001, 32'h0};
    vecs[22] = '{1'b0, 4'd2,  4'h0, 32'h0,         32'h0000_0001};
    vecs[23] = '{1'b1, 4'd0,  4'h1, 32'h0000_0001, 32'h0};
    vecs[24] = '{1'b0, 4'd0,  4'h0, 32'h0,         32'h0000_0001};
    vecs[25] = '{1'b1, 4'd3,  4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[26] = '{1'b0, 4'd3,  4'h0, 32'h0,         VER};
    vecs[27] = '{1'b0, 4'd15, 4'h0, 32'h0,         32'h0};
    vecs[28] = '{1'b1, 4'd15, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[29] = '{1'b0, 4'd15, 4'h0, 32'h0,         32'h0};
    vecs[30] = '{1'b1, 4'd9,  4'hF, 32'h0000_ABCD, 32'h0};
    vecs[31] = '{1'b0, 4'd9,  4'h0, 32'h0,         32'h0000_ABCD};

    reset = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.byteenable = '0; bus.writedata = '0;
    ch_busy = '0; ch_done = '0; ch_wrap = '0; ch_last_write_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", 64'(bus.readdata), 64'd0);
    chk("rst_rdvalid", 64'(bus.readdatavalid), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_enable", 64'(out_enable), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].be, vecs[i].data);
      else rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    chk("out_buf_start1", 64'(out_buf_start[63:32]), 64'hFFFF_0000);
    chk("out_buf_start0", 64'(out_buf_start[31:0]), 64'h78);
    chk("out_buf_size0", 64'(out_buf_size[31:0]), 64'hAABB_0000);
    chk("out_enable", 64'(out_enable), 64'd1);

    @(negedge clk);
    chk("rdvalid_single", 64'(bus.readdatavalid), 64'd0);
    chk("readdata_hold", 64'(bus.readdata), 64'h0000_ABCD);

    ch_busy = 2'b10;
    rd_chk(4'd0, 32'h8000_0001, "ctrl_busy");
    ch_busy = '0;

    pulse(2'b01, 2'b00);
    chk("irq_early", 64'(irq), 64'd0);
    pulse(2'b01, 2'b00);
    chk("irq_rise", 64'(irq), 64'd1);
    pulse(2'b01, 2'b00);
    rd_chk(4'd7, 32'd3, "pkt0_3");
    rd_chk(4'd1, 32'h1, "status_done0");
    wr(4'd1, 4'hF, 32'h0);
    rd_chk(4'd1, 32'h1, "w1c_zero_noeffect");
    wr(4'd1, 4'hF, 32'h1);
    chk("irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    chk("irq_fall", 64'(irq), 64'd0);

    ch_wrap = 2'b10;
    wr(4'd1, 4'hF, 32'h8);
    ch_wrap = '0;
    rd_chk(4'd1, 32'h8, "wrap_set_wins");
    chk("irq_masked", 64'(irq), 64'd0);
    wr(4'd1, 4'hF, 32'h8);
    rd_chk(4'd1, 32'h0, "wrap_cleared");

    wr(4'd7, 4'h0, 32'h0);
    rd_chk(4'd7, 32'd0, "pkt0_wrclr");
    pulse(2'b00, 2'b01);
    repeat (5) pulse(2'b01, 2'b00);
    rd_chk(4'd7, 32'd5, "pkt0_5");
    rd_chk(4'd1, 32'h3, "status_pre_soft");
    ch_done = 2'b01;
    wr(4'd0, 4'h0, 32'h2);
    ch_done = '0;
    rd_chk(4'd7, 32'd1, "soft_clr_with_done");
    rd_chk(4'd1, 32'h1, "soft_status");
    rd_chk(4'd0, 32'h1, "soft_enable");
    rd_chk(4'd2, 32'h1, "soft_mask");
    rd_chk(4'd5, 32'hAABB_0000, "soft_bufsize");

    pulse(2'b10, 2'b00);
    pulse(2'b10, 2'b00);
    rd_chk(4'd11, 32'd2, "pkt1_2");
    ch_done = 2'b10;
    wr(4'd11, 4'hF, 32'h0);
    ch_done = '0;
    rd_chk(4'd11, 32'd1, "pkt1_wrclr_done");

    ch_last_write_addr = {32'h0000_CAFE, 32'h0000_1234};
    wr(4'd6, 4'hF, 32'hFFFF_FFFF);
    rd_chk(4'd6, 32'h1234, "last_wr0_ro");
    rd_chk(4'd10, 32'hCAFE, "last_wr1");
    rd_chk(4'd15, 32'h0, "unmapped_rd");

    bus.address = 4'd8; bus.byteenable = 4'hF; bus.writedata = 32'h1111_1111;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    chk("rw_same_pre", 64'(bus.readdata), 64'hFFFF_0000);
    rd_chk(4'd8, 32'h1111_1111, "rw_same_post");
    chk("out_buf_start1_b", 64'(out_buf_start[63:32]), 64'h1111_1111);

    chk("irq_pre_rst", 64'(irq), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_readdata", 64'(bus.readdata), 64'd0);
    chk("rst2_irq", 64'(irq), 64'd0);
    chk("rst2_enable", 64'(out_enable), 64'd0);
    chk("rst2_buf_start", out_buf_start, 64'd0);
    reset = 1'b1;
    rd_chk(4'd2, 32'h0, "post_rst_mask");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/capture_csr_bank.md
Name: capture_csr_bank

Overview:
- Parametrised multi-channel CSR bank for the packet-capture datapath, accessed by the Linux driver over the H2F Avalon-MM slave.
- Per channel: capture-buffer configuration, live last-write address, packet counter.
- Global control, sticky done/wrap event flags with write-1-to-clear, per-bit interrupt mask, registered level interrupt to the HPS.
- Fixed one-cycle read latency with readdatavalid.

Parameters:
- N, 32: data width of all registers and bus; multiple of 8, N >= 2*NUM_CH and N >= NUM_CH+2.
- NUM_CH, 2: number of capture channels, >= 1.
- ADDR_W, 4: word-address width; 4+4*NUM_CH <= 2**ADDR_W.
- VERSION, 32'h0001_0000: constant returned at global address 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, single cycle
- write  in  1  write strobe, single cycle
- byteenable  in  N/8  byte lanes for writes to RW registers
- writedata  in  N  write data
- readdata  out  N  registered read data
- readdatavalid  out  1  high exactly one cycle after an accepted read
- irq  out  1  level interrupt, registered
- ch_busy  in  NUM_CH  live busy per channel
- ch_done  in  NUM_CH  one-cycle pulse per finished packet
- ch_wrap  in  NUM_CH  one-cycle pulse when the capture buffer wraps
- ch_last_write_addr  in  NUM_CH*N  live last SDRAM write address; channel c is at slice [c*N +: N]
- out_enable  out  1  CONTROL bit0
- out_buf_start  out  NUM_CH*N  per-channel BUF_START
- out_buf_size  out  NUM_CH*N  per-channel BUF_SIZE

Behaviour:
- Reset: clk is the clock. reset is synchronous and active-low. While reset=0, every register, readdata, readdatavalid and irq go to 0, and all outputs read 0.
- Address map, global registers:
  - 0 CONTROL: bit0 ENABLE is RW. bit1 SOFT_CLR is write-only and self-clearing; it reads 0. Bits [N-1 -: NUM_CH] return live ch_busy (RO). All other bits read 0.
  - 1 IRQ_STATUS: bit 2c is DONE[c]; bit 2c+1 is WRAP[c]. Flags are sticky. Writing 1 clears a bit; writing 0 has no effect.
  - 2 IRQ_MASK: RW. Only the low 2*NUM_CH bits are implemented.
  - 3 VERSION: RO constant (see Optional Feature).
- Address map, channel c (base 4+4c):
  - +0 BUF_START: RW.
  - +1 BUF_SIZE: RW.
  - +2 LAST_WR_ADDR: RO, live ch_last_write_addr slice.
  - +3 PKT_COUNT: RO. Any write clears it.
- Writes:
  - Take effect on the clock edge where write=1.
  - RW registers update only the bytes whose byteenable lane is set.
  - byteenable is ignored for W1C, SOFT_CLR and PKT_COUNT clear.
  - Writes to RO or unmapped addresses are ignored.
- Reads:
  - readdata is loaded on the edge where read=1, and readdatavalid=1 in the following cycle.
  - readdata holds its value until the next read.
  - Unmapped addresses return 0.
  - A read and a write to the same address in the same cycle return the pre-write value.
- Event flags:
  - A pulse on ch_done[c] or ch_wrap[c] sets the matching flag on the next edge.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- PKT_COUNT:
  - Increments on each ch_done[c] pulse and saturates at all-ones.
  - If a clear (write or SOFT_CLR) coincides with a done pulse, the count becomes 1.
- SOFT_CLR=1 write: on the same edge, clears all IRQ_STATUS bits and all PKT_COUNTs. It does not change configuration registers or the mask.
- irq: irq <= |(IRQ_STATUS & IRQ_MASK). irq rises one cycle after the flag is set and falls one cycle after the clear.
- Events are recorded regardless of ENABLE. ENABLE only drives out_enable.
- No back-pressure: waitrequest is not implemented, and every strobe is accepted.

Optional Feature:
- Macro: CSR_TIMESTAMP_EN.
- Defined:
  - Global address 3 returns a free-running N-bit cycle counter. It resets to 0, increments every clk, and wraps from all-ones to 0.
  - Each channel gains a per-channel done-timestamp register, RO, at address 4+4*NUM_CH+c. On each ch_done[c] pulse it captures the counter value of that cycle.
  - The map sizing rule becomes 4+5*NUM_CH <= 2**ADDR_W.
- Undefined: address 3 returns the VERSION parameter, and addresses beyond the channel blocks return 0.

Test Plan:
- Reset then read every mapped address -> all read 0, except address 3 = 32'h0001_0000. readdatavalid high exactly one cycle after each read.
- Write BUF_START[1] = 32'h2000_0000 with byteenable=4'b0011 after a full write of 32'hFFFF_FFFF -> reads 32'hFFFF_0000. out_buf_start[63:32] matches.
- ch_done[0] pulses x3 with IRQ_MASK=1 -> PKT_COUNT[0]=3, IRQ_STATUS=1, irq=1 one cycle after the first pulse. Write 1 to IRQ_STATUS -> irq=0 one cycle later.
- A ch_wrap[1] pulse coincides with a W1C write of 32'h8 -> IRQ_STATUS bit3 remains 1.
- PKT_COUNT preloaded to 5, then SOFT_CLR written while a ch_done[0] pulse is present -> PKT_COUNT[0]=1, other status bits 0, ENABLE unchanged.
- Read address 4'hF (unmapped) and write to LAST_WR_ADDR[0] with ch_last_write_addr[31:0]=32'h1234 -> unmapped read returns 0; LAST_WR_ADDR[0] still reads 32'h1234.
